// File: rtl/imuldiv_div_initiator.sv
// Front end for an iterative divider: handles divide-by-zero locally and
// replays the most recent divider result when the same operands come back.
module imuldiv_div_initiator (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_val,
    output logic        cmd_rdy,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic        resp_val,
    input  logic        resp_rdy,
    output logic [31:0] resp_data,
    output logic        divreq_val,
    input  logic        divreq_rdy,
    output logic        divreq_msg_fn,
    output logic [31:0] divreq_msg_a,
    output logic [31:0] divreq_msg_b,
    input  logic        divresp_val,
    output logic        divresp_rdy,
    input  logic [63:0] divresp_msg_result,
    output logic [7:0]  reuse_cnt
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q;
    logic        fn_q;

    logic        cache_valid;
    logic [31:0] cache_a, cache_b;
    logic        cache_fn;
    logic [63:0] cache_result;

    logic        cmd_fn;
    logic        b_zero;
    logic        cache_hit;
    logic        cmd_xfer;
    logic        divresp_xfer;

    assign cmd_fn       = ~cmd_op[0];
    assign b_zero       = (cmd_b == '0);
    assign cache_hit    = cache_valid && (cmd_a == cache_a) && (cmd_b == cache_b)
                          && (cmd_fn == cache_fn);
    assign cmd_xfer     = cmd_val && cmd_rdy;
    assign divresp_xfer = divresp_val && divresp_rdy;

    assign divreq_msg_fn = fn_q;
    assign divreq_msg_a  = a_q;
    assign divreq_msg_b  = b_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_rdy     = 1'b0;
        divreq_val  = 1'b0;
        divresp_rdy = 1'b0;
        resp_val    = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_rdy = 1'b1;
                if (cmd_val) begin
                    state_d = (b_zero || cache_hit) ? RESP : REQ;
                end
            end
            REQ: begin
                divreq_val = 1'b1;
                if (divreq_rdy) state_d = WAIT;
            end
            WAIT: begin
                divresp_rdy = 1'b1;
                if (divresp_val) state_d = RESP;
            end
            RESP: begin
                resp_val = 1'b1;
                if (resp_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Divide-by-zero answers follow the RISC-V convention and never touch the cache.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            fn_q         <= 1'b0;
            cache_valid  <= 1'b0;
            cache_a      <= '0;
            cache_b      <= '0;
            cache_fn     <= 1'b0;
            cache_result <= '0;
            resp_data    <= '0;
            reuse_cnt    <= '0;
        end else begin
            if (cmd_xfer) begin
                op_q <= cmd_op;
                a_q  <= cmd_a;
                b_q  <= cmd_b;
                fn_q <= cmd_fn;
                if (b_zero) begin
                    resp_data <= cmd_op[1] ? cmd_a : '1;
                end else if (cache_hit) begin
                    resp_data <= cmd_op[1] ? cache_result[63:32] : cache_result[31:0];
                    reuse_cnt <= reuse_cnt + 8'd1;
                end
            end
            if (divresp_xfer) begin
                cache_valid  <= 1'b1;
                cache_a      <= a_q;
                cache_b      <= b_q;
                cache_fn     <= fn_q;
                cache_result <= divresp_msg_result;
                resp_data    <= op_q[1] ? divresp_msg_result[63:32]
                                        : divresp_msg_result[31:0];
            end
        end
    end

endmodule

// File: tb/tb_imuldiv_div_initiator.sv
// Directed bench for imuldiv_div_initiator with a behavioural divider responder.
module tb_imuldiv_div_initiator;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_val = 1'b0;
    logic        cmd_rdy;
    logic [1:0]  cmd_op = '0;
    logic [31:0] cmd_a = '0, cmd_b = '0;
    logic        resp_val;
    logic        resp_rdy = 1'b0;
    logic [31:0] resp_data;
    logic        divreq_val;
    logic        divreq_rdy = 1'b0;
    logic        divreq_msg_fn;
    logic [31:0] divreq_msg_a, divreq_msg_b;
    logic        divresp_val = 1'b0;
    logic        divresp_rdy;
    logic [63:0] divresp_msg_result = '0;
    logic [7:0]  reuse_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_reuse = '0;

    always #5 clk = ~clk;

    imuldiv_div_initiator dut (
        .clk(clk), .reset(reset),
        .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_data(resp_data),
        .divreq_val(divreq_val), .divreq_rdy(divreq_rdy), .divreq_msg_fn(divreq_msg_fn),
        .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
        .divresp_val(divresp_val), .divresp_rdy(divresp_rdy),
        .divresp_msg_result(divresp_msg_result), .reuse_cnt(reuse_cnt)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          req;
        bit          hit;
        bit          stall;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] div_model(input logic fn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (fn) begin
            if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
                q = a;
                r = '0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    task automatic run_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input bit exp_req, input bit exp_hit,
                           input bit stall);
        int          reqs = 0;
        int          dly = 0;
        bit          done = 1'b0;
        bit          pend = 1'b0;
        bit          after_rsp = 1'b0;
        bit          req_x, rsp_x, out_x;
        logic [63:0] res = '0;
        logic        cap_fn;
        logic [31:0] cap_a, cap_b;

        @(negedge clk);
        cmd_val = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        check("cmd_rdy_idle", {63'd0, cmd_rdy}, 64'd1);
        @(posedge clk);
        if (exp_hit) exp_reuse = exp_reuse + 8'd1;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(negedge clk);
            cmd_val = 1'b0;
            if (cyc == 0) begin
                check("lat_divreq", {63'd0, divreq_val}, {63'd0, exp_req});
                check("lat_resp", {63'd0, resp_val}, {63'd0, !exp_req});
            end
            if (after_rsp) begin
                check("lat_resp_div", {63'd0, resp_val}, 64'd1);
                after_rsp = 1'b0;
            end
            check("cmd_rdy_busy", {63'd0, cmd_rdy}, 64'd0);
            req_x = 1'b0;
            if (divreq_val) begin
                check("divreq_a", {32'd0, divreq_msg_a}, {32'd0, a});
                check("divreq_b", {32'd0, divreq_msg_b}, {32'd0, b});
                check("divreq_fn", {63'd0, divreq_msg_fn}, {63'd0, ~op[0]});
                cap_fn = divreq_msg_fn; cap_a = divreq_msg_a; cap_b = divreq_msg_b;
                divreq_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                req_x = divreq_rdy;
            end else begin
                divreq_rdy = 1'b0;
            end
            rsp_x = 1'b0;
            if (pend) begin
                if (dly > 0) begin
                    dly--;
                    divresp_val = 1'b0;
                end else begin
                    divresp_val = 1'b1;
                    divresp_msg_result = res;
                    check("divresp_rdy_wait", {63'd0, divresp_rdy}, 64'd1);
                    rsp_x = divresp_rdy;
                end
            end else begin
                divresp_val = 1'b0;
            end
            out_x = 1'b0;
            if (resp_val) begin
                check("resp_data", {32'd0, resp_data}, {32'd0, exp});
                resp_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                out_x = resp_rdy;
            end else begin
                resp_rdy = 1'b0;
            end
            @(posedge clk);
            if (req_x) begin
                reqs++;
                res  = div_model(cap_fn, cap_a, cap_b);
                pend = 1'b1;
                dly  = stall ? $urandom_range(0, 3) : 0;
            end
            if (rsp_x) begin
                pend = 1'b0;
                after_rsp = 1'b1;
            end
            if (out_x) done = 1'b1;
        end
        @(negedge clk);
        resp_rdy = 1'b0; divresp_val = 1'b0; divreq_rdy = 1'b0;
        check("completed", {63'd0, done}, 64'd1);
        check("divreq_count", 64'(reqs), {63'd0, exp_req});
        check("reuse_cnt", {56'd0, reuse_cnt}, {56'd0, exp_reuse});
        check("cmd_rdy_after", {63'd0, cmd_rdy}, 64'd1);
    endtask

    initial begin
        int accepts;
        vecs[0]  = '{2'b00, 32'h0000_0222, 32'h0000_002a, 32'h0000_000d, 1, 0, 0};
        vecs[1]  = '{2'b10, 32'h0000_0222, 32'h0000_002a, 32'h0000_0000, 0, 1, 0};
        vecs[2]  = '{2'b01, 32'h57dc_898a, 32'h3577_91c0, 32'h0000_0001, 1, 0, 0};
        vecs[3]  = '{2'b11, 32'h57dc_898a, 32'h3577_91c0, 32'h2264_f7ca, 0, 1, 0};
        vecs[4]  = '{2'b10, 32'h57dc_898a, 32'h3577_91c0, 32'h2264_f7ca, 1, 0, 0};
        vecs[5]  = '{2'b00, 32'hdead_beef, 32'h0000_0000, 32'hffff_ffff, 0, 0, 0};
        vecs[6]  = '{2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 0, 0, 0};
        vecs[7]  = '{2'b00, 32'h57dc_898a, 32'h3577_91c0, 32'h0000_0001, 0, 1, 0};
        vecs[8]  = '{2'b00, 32'hdead_beef, 32'h0000_beef, 32'hffff_d353, 1, 0, 1};
        vecs[9]  = '{2'b10, 32'hdead_beef, 32'h0000_beef, 32'hffff_da72, 0, 1, 0};
        vecs[10] = '{2'b00, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 1, 0, 0};
        vecs[11] = '{2'b01, 32'hffff_ffff, 32'h0000_0010, 32'h0fff_ffff, 1, 0, 0};
        vecs[12] = '{2'b11, 32'h0000_0010, 32'hffff_ffff, 32'h0000_0010, 1, 0, 0};

        repeat (2) @(negedge clk);
        check("rst_cmd_rdy", {63'd0, cmd_rdy}, 64'd1);
        check("rst_resp_val", {63'd0, resp_val}, 64'd0);
        check("rst_divreq_val", {63'd0, divreq_val}, 64'd0);
        check("rst_divresp_rdy", {63'd0, divresp_rdy}, 64'd0);
        check("rst_resp_data", {32'd0, resp_data}, 64'd0);
        check("rst_reuse_cnt", {56'd0, reuse_cnt}, 64'd0);
        reset = 1'b1;

        for (int i = 0; i < 13; i++)
            run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
                    vecs[i].req, vecs[i].hit, vecs[i].stall);

        // Reset while waiting on the divider, then a stray late response.
        @(negedge clk);
        cmd_val = 1'b1; cmd_op = 2'b00; cmd_a = 32'h0000_1000; cmd_b = 32'h0000_0007;
        @(posedge clk);
        @(negedge clk);
        cmd_val = 1'b0;
        check("abort_divreq_val", {63'd0, divreq_val}, 64'd1);
        divreq_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        divreq_rdy = 1'b0;
        check("abort_in_wait", {63'd0, divresp_rdy}, 64'd1);
        reset = 1'b0;
        #1;
        exp_reuse = '0;
        check("abort_cmd_rdy", {63'd0, cmd_rdy}, 64'd1);
        check("abort_divresp_rdy", {63'd0, divresp_rdy}, 64'd0);
        check("abort_resp_val", {63'd0, resp_val}, 64'd0);
        check("abort_reuse_cnt", {56'd0, reuse_cnt}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        divresp_val = 1'b1;
        divresp_msg_result = 64'h0000_0001_0000_0249;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_resp_val", {63'd0, resp_val}, 64'd0);
            check("late_divresp_rdy", {63'd0, divresp_rdy}, 64'd0);
        end
        divresp_val = 1'b0;
        run_cmd(2'b00, 32'h0000_1000, 32'h0000_0007, 32'h0000_0249, 1, 0, 0);

        // Hits until reuse_cnt wraps.
        for (int i = 0; i < 255; i++)
            run_cmd(2'b00, 32'h0000_1000, 32'h0000_0007, 32'h0000_0249, 0, 1, 0);
        check("reuse_cnt_ff", {56'd0, reuse_cnt}, 64'h0000_0000_0000_00ff);
        run_cmd(2'b10, 32'h0000_1000, 32'h0000_0007, 32'h0000_0001, 0, 1, 0);
        check("reuse_cnt_wrap", {56'd0, reuse_cnt}, 64'd0);

        // Command held valid: only every other cycle may accept.
        accepts = 0;
        @(negedge clk);
        cmd_val = 1'b1; cmd_op = 2'b00; cmd_a = 32'h0000_0005; cmd_b = 32'h0;
        resp_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (cmd_val && cmd_rdy) accepts++;
            check("no_overlap", {63'd0, cmd_rdy && resp_val}, 64'd0);
            if (resp_val) check("b2b_resp_data", {32'd0, resp_data}, 64'h0000_0000_ffff_ffff);
            @(negedge clk);
        end
        cmd_val = 1'b0;
        resp_rdy = 1'b0;
        check("b2b_accepts", 64'(accepts), 64'd3);
        check("b2b_idle", {63'd0, cmd_rdy}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
